// File: rtl/frame_window_if.sv
// Stream bundle around frame_window: sample input side with frame/bypass qualifiers
// and windowed output side. master = environment, slave = windowing stage.
interface frame_window_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] s_data_in;
    logic                  s_valid_in;
    logic                  s_ready_out;
    logic                  frame_sync_in;
    logic                  bypass_in;
    logic [DATA_WIDTH-1:0] m_data_out;
    logic                  m_valid_out;
    logic                  m_ready_in;
    logic                  m_last_out;

    modport master (
        output s_data_in, s_valid_in, frame_sync_in, bypass_in, m_ready_in,
        input  s_ready_out, m_data_out, m_valid_out, m_last_out
    );

    modport slave (
        input  s_data_in, s_valid_in, frame_sync_in, bypass_in, m_ready_in,
        output s_ready_out, m_data_out, m_valid_out, m_last_out
    );
endinterface

// File: rtl/frame_window.sv
// Frame-aware windowing stage: 3-stage pipeline, half-size symmetric coefficient table.
// Build option FRAME_WINDOW_ROUND_EN selects round-half-up instead of floor.
module frame_window #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAME_LEN   = 4096,
    parameter logic [COEFF_WIDTH*(FRAME_LEN/2)-1:0] COEFF_TABLE = '0
) (
    input logic           clk_in,
    input logic           rst_n_in,
    frame_window_if.slave bus
);
    localparam int IW   = $clog2(FRAME_LEN);
    localparam int AW   = IW - 1;
    localparam int HALF = FRAME_LEN / 2;
    localparam int PW   = DATA_WIDTH + COEFF_WIDTH + 1;

    // Handshake: a beat transfers on a rising edge where valid && ready are both high;
    // valid and its payload stay stable until that edge. All stages move together on en.
    logic en;
    logic accept;
    assign en              = !bus.m_valid_out || bus.m_ready_in;
    assign bus.s_ready_out = en;
    assign accept          = bus.s_valid_in && en;

    logic [COEFF_WIDTH-1:0] rom [HALF];
    for (genvar i = 0; i < HALF; i++) begin : g_rom
        assign rom[i] = COEFF_TABLE[i*COEFF_WIDTH +: COEFF_WIDTH];
    end

    logic [IW-1:0] next_idx;
    logic [IW-1:0] cur_idx;
    logic [AW-1:0] addr;
    assign cur_idx = bus.frame_sync_in ? '0 : next_idx;
    // Upper half mirrors the lower: FRAME_LEN-1-idx is the complement of the low bits.
    assign addr    = cur_idx[IW-1] ? ~cur_idx[AW-1:0] : cur_idx[AW-1:0];

    logic                   s1_valid, s1_bypass, s1_last;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic [AW-1:0]          s1_addr;
    logic                   s2_valid, s2_bypass, s2_last;
    logic [DATA_WIDTH-1:0]  s2_data;
    logic [COEFF_WIDTH-1:0] rom_q;

    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] coeff_ext;
    logic signed [PW-1:0] product;
    logic signed [PW-1:0] biased;
    assign data_ext  = {{(COEFF_WIDTH+1){s2_data[DATA_WIDTH-1]}}, s2_data};
    assign coeff_ext = {{(DATA_WIDTH+1){1'b0}}, rom_q};
    assign product   = data_ext * coeff_ext;
`ifdef FRAME_WINDOW_ROUND_EN
    localparam logic signed [PW-1:0] ROUND_BIAS =
        {{(DATA_WIDTH+1){1'b0}}, 1'b1, {(COEFF_WIDTH-1){1'b0}}};
    assign biased = product + ROUND_BIAS;
`else
    assign biased = product;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            next_idx        <= '0;
            s1_valid        <= 1'b0;
            s1_bypass       <= 1'b0;
            s1_last         <= 1'b0;
            s1_data         <= '0;
            s1_addr         <= '0;
            s2_valid        <= 1'b0;
            s2_bypass       <= 1'b0;
            s2_last         <= 1'b0;
            s2_data         <= '0;
            rom_q           <= '0;
            bus.m_valid_out <= 1'b0;
            bus.m_data_out  <= '0;
            bus.m_last_out  <= 1'b0;
        end else begin
            if (accept) begin
                next_idx <= cur_idx + IW'(1);
            end
            if (en) begin
                s1_valid        <= bus.s_valid_in;
                s1_bypass       <= bus.bypass_in;
                s1_last         <= &cur_idx;
                s1_data         <= bus.s_data_in;
                s1_addr         <= addr;
                rom_q           <= rom[s1_addr];
                s2_valid        <= s1_valid;
                s2_bypass       <= s1_bypass;
                s2_last         <= s1_last;
                s2_data         <= s1_data;
                bus.m_valid_out <= s2_valid;
                bus.m_last_out  <= s2_valid && s2_last;
                if (s2_valid) begin
                    bus.m_data_out <= s2_bypass ? s2_data
                                                : DATA_WIDTH'(biased >>> COEFF_WIDTH);
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_window.sv
// Bench for frame_window (FRAME_LEN=8, table {0x0000,0x4000,0x8000,0xFFFF}):
// random and directed streams against a reference model with a queued scoreboard.
module tb_frame_window;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int FL = 8;

    logic clk_in;
    logic rst_n_in;
    frame_window_if #(.DATA_WIDTH(DW)) bus ();

    frame_window #(
        .DATA_WIDTH (DW),
        .COEFF_WIDTH(CW),
        .FRAME_LEN  (FL),
        .COEFF_TABLE(64'hFFFF_8000_4000_0000)
    ) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .bus     (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int  tbl [4] = '{0, 16384, 32768, 65535};
    int  model_next = 0;
    bit  rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model(input int x, input int idx, input bit byp);
        int     a;
        longint p;
        a = (idx < FL / 2) ? idx : FL - 1 - idx;
        p = longint'(x) * longint'(tbl[a]);
`ifdef FRAME_WINDOW_ROUND_EN
        p = p + 32768;
`endif
        if (byp) return DW'(x);
        return DW'(p >>> CW);
    endfunction

    // Called at a falling edge; returns at the falling edge after the sample is taken.
    task automatic drive(input int x, input bit sync, input bit byp);
        bit done;
        int idx;
        bit rdy;
        done = 1'b0;
        bus.s_data_in     = DW'(x);
        bus.frame_sync_in = sync;
        bus.bypass_in     = byp;
        bus.s_valid_in    = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            #1 rdy = bus.s_ready_out;
            @(posedge clk_in);
            if (rdy) begin
                done = 1'b1;
                idx = sync ? 0 : model_next;
                model_next = (idx + 1) % FL;
                exp_q.push_back(model(x, idx, byp));
                exp_last_q.push_back(idx == FL - 1);
            end
            @(negedge clk_in);
        end
        if (!done) check("drive_timeout", 0, 1);
        bus.s_valid_in    = 1'b0;
        bus.frame_sync_in = 1'b0;
        bus.bypass_in     = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk_in);
        check("drain_empty", exp_q.size(), 0);
    endtask

    always begin
        @(negedge clk_in);
        if (rand_ready) bus.m_ready_in = ($urandom_range(0, 3) != 0);
    end

    // Monitor: snapshot between edges, pop on every output handshake.
    initial begin
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        logic          prev_last  = 1'b0;
        logic [DW-1:0] e_data;
        logic          e_last;
        forever begin
            @(negedge clk_in);
            #2;
            if (!rst_n_in) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", int'(bus.m_valid_out), 1);
                    check("hold_data", int'($signed(bus.m_data_out)), int'($signed(prev_data)));
                    check("hold_last", int'(bus.m_last_out), int'(prev_last));
                end
                if (bus.m_valid_out && bus.m_ready_in) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", int'($signed(bus.m_data_out)), -99999);
                    end else begin
                        e_data = exp_q.pop_front();
                        e_last = exp_last_q.pop_front();
                        check("out_data", int'($signed(bus.m_data_out)), int'($signed(e_data)));
                        check("out_last", int'(bus.m_last_out), int'(e_last));
                    end
                end
                prev_stall = bus.m_valid_out && !bus.m_ready_in;
                prev_data  = bus.m_data_out;
                prev_last  = bus.m_last_out;
            end
        end
    end

    initial begin
        rst_n_in          = 1'b0;
        bus.s_data_in     = '0;
        bus.s_valid_in    = 1'b0;
        bus.frame_sync_in = 1'b0;
        bus.bypass_in     = 1'b0;
        bus.m_ready_in    = 1'b1;
        #3;
        check("rst_m_valid", int'(bus.m_valid_out), 0);
        check("rst_m_data", int'(bus.m_data_out), 0);
        check("rst_m_last", int'(bus.m_last_out), 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 check("rst_s_ready", int'(bus.s_ready_out), 1);
        @(negedge clk_in);

        // First-sample latency: taken at edge E1, visible after E3.
        drive(1000, 1'b0, 1'b0);
        @(posedge clk_in);
        #1 check("latency_not_yet", int'(bus.m_valid_out), 0);
        @(posedge clk_in);
        #1 check("latency_valid", int'(bus.m_valid_out), 1);
        @(negedge clk_in);
        drain();

        // Constant stream over two frames: 0,250,500,999,999,500,250,0.
        for (int i = 0; i < 2 * FL; i++) drive(1000, i == 0, 1'b0);
        drain();

        // Negative product and small-value rounding at index 1.
        drive(0, 1'b1, 1'b0);
        drive(-1000, 1'b0, 1'b0);
        drive(0, 1'b1, 1'b0);
        drive(3, 1'b0, 1'b0);
        drain();

        // Bypass keeps full-scale negative value; last marker still advances.
        for (int i = 0; i < 2 * FL; i++) drive(-32768, i == 0, 1'b1);
        drain();

        // Resync on the 4th sample of a frame.
        for (int i = 0; i < 12; i++) drive(1000, (i == 0) || (i == 3), 1'b0);
        drain();

        // Random stream with random downstream backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            drive(int'($urandom_range(0, 65535)) - 32768,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end
        @(negedge clk_in);
        rand_ready     = 1'b0;
        bus.m_ready_in = 1'b1;
        drain();

        // Five-cycle downstream stall while the source keeps offering samples.
        fork
            begin
                for (int i = 0; i < 16; i++) drive(int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk_in);
                bus.m_ready_in = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1 check("stall_s_ready", int'(bus.s_ready_out), 0);
                    @(negedge clk_in);
                end
                bus.m_ready_in = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three samples in flight, mid-frame.
        drive(1000, 1'b1, 1'b0);
        drive(1000, 1'b0, 1'b0);
        drive(1000, 1'b0, 1'b0);
        rst_n_in = 1'b0;
        #1;
        check("arst_m_valid", int'(bus.m_valid_out), 0);
        check("arst_m_data", int'(bus.m_data_out), 0);
        check("arst_m_last", int'(bus.m_last_out), 0);
        exp_q.delete();
        exp_last_q.delete();
        model_next = 0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 check("arst_s_ready", int'(bus.s_ready_out), 1);
        @(negedge clk_in);
        drive(1000, 1'b0, 1'b0);
        drive(1000, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/frame_window.md
# frame_window

Parametrised, frame-aware windowing stage for the audio-to-FFT path: multiplies each incoming signed sample by a per-index window coefficient and emits the windowed sample downstream with full valid/ready backpressure. Generalises the fixed 8-bit, 4096-point Hanning stage with configurable widths and frame length, a half-size symmetric coefficient table, frame resynchronisation, a frame-last marker and a per-sample bypass mode. Sits between the audio sample source and the FFT input buffer.

## Interface
- DATA_WIDTH, 16: signed sample width in and out.
- COEFF_WIDTH, 16: unsigned coefficient width; coefficient value = c / 2^COEFF_WIDTH, c in [0, 2^COEFF_WIDTH-1].
- FRAME_LEN, 4096: samples per frame; power of two, >= 4.
- INIT_FILE, "window_half.mem": hex file holding FRAME_LEN/2 coefficient words for indices 0..FRAME_LEN/2-1.

- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- s_data_in  input  DATA_WIDTH  signed input sample.
- s_valid_in  input  1  input sample valid.
- s_ready_out  output  1  block can accept a sample this cycle.
- frame_sync_in  input  1  qualifies s_data_in: the accepted sample is frame index 0.
- bypass_in  input  1  qualifies s_data_in: pass the sample through with coefficient 1.0.
- m_data_out  output  DATA_WIDTH  signed windowed sample.
- m_valid_out  output  1  output sample valid.
- m_ready_in  input  1  downstream accepts output.
- m_last_out  output  1  output sample is frame index FRAME_LEN-1.

## Operation
- Accept = s_valid_in && s_ready_out. Frame index counter idx (log2(FRAME_LEN) bits) assigned per accepted sample: idx = 0 if frame_sync_in, else previous idx+1, wrapping FRAME_LEN-1 -> 0. First accepted sample after reset is index 0.
- Table address: a = idx for idx < FRAME_LEN/2, else FRAME_LEN-1-idx. Table is a ROM with exactly one cycle read latency, read enabled only when the pipeline advances.
- Pipeline: stage 1 registers sample, bypass, last flag and ROM address; stage 2 holds ROM output alongside the sample; stage 3 registers the product result into m_data_out.
- Arithmetic: product = s_data (signed) × {1'b0, c} (signed), width DATA_WIDTH+COEFF_WIDTH+1; result = product arithmetically shifted right by COEFF_WIDTH, truncated to DATA_WIDTH. Since c < 2^COEFF_WIDTH, no overflow is possible; no saturation logic.
- Bypass: m_data_out = input sample exactly, unaffected by rounding; index counter and m_last_out still advance normally.
- m_last_out asserted with the output sample whose idx = FRAME_LEN-1.

## Timing
- Reset (rst_n_in low, any cycle): m_valid_out=0, m_data_out=0, m_last_out=0, idx restarts at 0, all stage valids cleared; in-flight samples discarded. s_ready_out=1 after release.
- Pipeline enable en = !m_valid_out || m_ready_in; s_ready_out = en (combinational). When en=0 all stages and ROM output hold.
- Latency: sample accepted in cycle T appears on m_data_out with m_valid_out=1 in cycle T+3 when no stall. Full throughput: one sample per cycle with m_ready_in held high.
- Output holds m_data_out/m_last_out stable while m_valid_out && !m_ready_in.
- Bubbles: a stage without valid data propagates valid=0; m_valid_out drops after a consumed sample when no data follows.
- frame_sync_in on a non-accepted cycle is ignored. frame_sync_in on the sample that would have been index 0 anyway has no visible effect.
- Simultaneous frame_sync_in and bypass_in: both apply.

## Configuration
- FRAME_WINDOW_ROUND_EN defined: add 2^(COEFF_WIDTH-1) to product before the shift (round half up); result still cannot overflow DATA_WIDTH.
- Not defined: pure truncation (floor) as above. Bypass path identical in both builds.

## Test plan
- DATA_WIDTH=16, COEFF_WIDTH=16, FRAME_LEN=8, table {0x0000,0x4000,0x8000,0xFFFF}; stream constant 1000, m_ready_in=1 -> outputs 0,250,500,999,999,500,250,0 from cycle T+3, m_last_out only on the 8th, next frame repeats.
- Same table, sample -1000 at idx 1, truncation build -> -250; sample 3 at idx 1: truncation -> 0, FRAME_WINDOW_ROUND_EN -> 1.
- bypass_in=1 on all samples of value -32768 -> every output -32768, m_last_out still on every 8th output.
- frame_sync_in on the 4th sample of a frame -> that sample uses coefficient 0x0000 (output 0), m_last_out 7 samples later.
- m_ready_in low for 5 cycles mid-stream with s_valid_in high -> s_ready_out low within those cycles, m_data_out stable, no sample lost or duplicated, order preserved.
- rst_n_in pulsed low asynchronously mid-frame with 3 samples in flight -> m_valid_out=0, m_data_out=0 immediately; next accepted sample windowed as index 0.
